// File: rtl/sc_frame_serializer_if.sv
// Slow-control serializer bundle: configuration-side handshake plus ASIC chain pins.
// slave is the serializer's view; master is the controller/bench view.
interface sc_frame_serializer_if #(
  parameter int TOTAL = 829
);
  logic             start_in;
  logic             verify_en_in;
  logic [TOTAL-1:0] frame_in;
  logic             Q_SC_in;
  logic             D_SC_out;
  logic             RSTn_SC_out;
  logic             CK_SC_out;
  logic             busy_out;
  logic             done_out;
  logic             err_out;
  logic [15:0]      mismatch_cnt_out;
  logic [2:0]       state_out;

  modport slave (
    input  start_in, verify_en_in, frame_in, Q_SC_in,
    output D_SC_out, RSTn_SC_out, CK_SC_out, busy_out, done_out,
           err_out, mismatch_cnt_out, state_out
  );

  modport master (
    output start_in, verify_en_in, frame_in, Q_SC_in,
    input  D_SC_out, RSTn_SC_out, CK_SC_out, busy_out, done_out,
           err_out, mismatch_cnt_out, state_out
  );
endinterface

// File: rtl/sc_frame_serializer.sv
// Daisy-chain slow-control frame serializer for MAROC ASICs: chip reset pulse,
// LSB-first shift with divided CK_SC, optional readback compare on Q_SC.
module sc_frame_serializer #(
  parameter int FRAME_W = 829,
  parameter int N_CHIP  = 1,
  parameter int DIV     = 1,
  parameter int RST_CYC = 4
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  sc_frame_serializer_if.slave sc
);

  localparam int TOTAL = FRAME_W * N_CHIP;
  localparam int BIT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int PH_W  = $clog2(2 * DIV);
  localparam int RC_W  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(TOTAL - 1);
  localparam logic [PH_W-1:0]  PH_LAST     = PH_W'(2 * DIV - 1);
  localparam logic [PH_W-1:0]  PH_LOW_LAST = PH_W'(DIV - 1);
  localparam logic [PH_W-1:0]  PH_HIGH     = PH_W'(DIV);
  localparam logic [RC_W-1:0]  RC_LAST     = RC_W'(RST_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST      = 3'd1,
    S_SHIFT    = 3'd2,
    S_DONE     = 3'd3,
    S_READBACK = 3'd4
  } state_t;

  state_t           state;
  logic [TOTAL-1:0] shadow;
  logic             verify_mode;
  logic [BIT_W-1:0] bit_idx;
  logic [PH_W-1:0]  phase;
  logic [RC_W-1:0]  rst_cnt;
  logic             d_sc;
  logic             ck_sc;
  logic             rstn_sc;
  logic             busy;
  logic             done;
  logic             err;
  logic [15:0]      mis_cnt;

  logic [BIT_W-1:0] bit_nxt;
  logic [PH_W-1:0]  phase_nxt;

  assign bit_nxt   = bit_idx + BIT_W'(1);
  assign phase_nxt = phase + PH_W'(1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Frame and mode are captured once per accepted start and held for both passes.
  always_ff @(posedge clk_in) begin
    if (state == S_IDLE && sc.start_in) begin
      shadow      <= sc.frame_in;
      verify_mode <= sc.verify_en_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state   <= S_IDLE;
      bit_idx <= '0;
      phase   <= '0;
      rst_cnt <= '0;
      d_sc    <= 1'b0;
      ck_sc   <= 1'b0;
      rstn_sc <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      mis_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          d_sc  <= 1'b0;
          ck_sc <= 1'b0;
          done  <= 1'b0;
          if (sc.start_in) begin
            state   <= S_RST;
            rst_cnt <= '0;
            rstn_sc <= 1'b0;
            busy    <= 1'b1;
            err     <= 1'b0;
            mis_cnt <= '0;
          end
        end

        S_RST: begin
          if (rst_cnt == RC_LAST) begin
            state   <= S_SHIFT;
            rstn_sc <= 1'b1;
            bit_idx <= '0;
            phase   <= '0;
            d_sc    <= shadow[0];
            ck_sc   <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end

        S_SHIFT, S_READBACK: begin
          // Q_SC is taken in the last low-phase cycle, just before CK_SC rises.
          if (state == S_READBACK && phase == PH_LOW_LAST &&
              sc.Q_SC_in != shadow[bit_idx]) begin
            err     <= 1'b1;
            mis_cnt <= sat_inc(mis_cnt);
          end
          if (phase == PH_LAST) begin
            phase <= '0;
            ck_sc <= 1'b0;
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
              if (state == S_SHIFT && verify_mode) begin
                state <= S_READBACK;
                d_sc  <= shadow[0];
              end else begin
                state <= S_DONE;
                d_sc  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              bit_idx <= bit_nxt;
              d_sc    <= shadow[bit_nxt];
            end
          end else begin
            phase <= phase_nxt;
            ck_sc <= (phase_nxt >= PH_HIGH);
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          d_sc  <= 1'b0;
          ck_sc <= 1'b0;
        end

        default: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          rstn_sc <= 1'b1;
          d_sc    <= 1'b0;
          ck_sc   <= 1'b0;
        end
      endcase
    end
  end

  assign sc.D_SC_out         = d_sc;
  assign sc.CK_SC_out        = ck_sc;
  assign sc.RSTn_SC_out      = rstn_sc;
  assign sc.busy_out         = busy;
  assign sc.done_out         = done;
  assign sc.err_out          = err;
  assign sc.mismatch_cnt_out = mis_cnt;
  assign sc.state_out        = state;

endmodule

// File: tb/tb_sc_frame_serializer.sv
// Directed bench for sc_frame_serializer: table of whole transfers plus
// hand-written reset, disturbance, back-to-back and default-size sequences.
module tb_sc_frame_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic zero_q;
  logic [15:0] chain_sr = '0;

  sc_frame_serializer_if #(.TOTAL(16))  sc ();
  sc_frame_serializer_if #(.TOTAL(829)) scd ();

  sc_frame_serializer #(.FRAME_W(8), .N_CHIP(2), .DIV(2), .RST_CYC(3)) dut (
    .clk_in   (clk),
    .reset_in (rst_n),
    .sc       (sc)
  );

  sc_frame_serializer dut_def (
    .clk_in   (clk),
    .reset_in (rst_n),
    .sc       (scd)
  );

  // 16-stage chain model: every CK_SC rising edge moves one bit toward Q_SC.
  always @(posedge sc.CK_SC_out) chain_sr <= {sc.D_SC_out, chain_sr[15:1]};
  assign sc.Q_SC_in  = zero_q ? 1'b0 : chain_sr[0];
  assign scd.Q_SC_in = 1'b0;

  typedef struct {
    logic [15:0] frame;
    logic        ve;
    logic        zq;
    int          exp_done;
    int          exp_rises;
    logic        exp_err;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[6];

  int n_chk = 0;
  int n_pass = 0;

  int r_done, r_rises, r_rst_low, r_rst_first, r_rst_last, r_first_rise;
  int r_bad_space, r_bad_d, r_busy_low, r_err_k1, r_done_state, r_cnt;
  logic [15:0] r_pass1, r_pass2;
  logic r_done_d, r_done_ck, r_err;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic launch(input logic [15:0] fr, input logic ve);
    @(negedge clk);
    sc.frame_in     = fr;
    sc.verify_en_in = ve;
    sc.start_in     = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Samples cycles t0+1, t0+2, ... on the falling edge until done_out.
  task automatic capture(input bit disturb, input bit keep_start, input int max_k);
    logic prev_ck, prev_d;
    int   prev_st, last_rise;
    prev_ck = 1'b0; prev_d = 1'b0; prev_st = 0; last_rise = 0;
    r_done = -1; r_rises = 0; r_rst_low = 0; r_rst_first = -1; r_rst_last = -1;
    r_first_rise = -1; r_bad_space = 0; r_bad_d = 0; r_busy_low = 0; r_err_k1 = -1;
    r_pass1 = '0; r_pass2 = '0;
    for (int k = 1; k <= max_k; k++) begin
      @(negedge clk);
      if (disturb && k == 30) begin
        sc.start_in = 1'b1;
        sc.frame_in = 16'hFFFF;
      end
      if (disturb && k == 40) sc.start_in = 1'b0;
      if (k == 1) r_err_k1 = int'(sc.err_out);
      if (!sc.RSTn_SC_out) begin
        r_rst_low++;
        if (r_rst_first < 0) r_rst_first = k;
        r_rst_last = k;
      end
      if (!sc.busy_out) r_busy_low++;
      if (sc.CK_SC_out && !prev_ck) begin
        if (r_rises < 16) r_pass1[r_rises] = sc.D_SC_out;
        else if (r_rises < 32) r_pass2[r_rises-16] = sc.D_SC_out;
        if (r_rises == 0) r_first_rise = k;
        else if (k - last_rise != 4) r_bad_space++;
        last_rise = k;
        r_rises++;
      end
      if (sc.D_SC_out != prev_d && !(prev_ck && !sc.CK_SC_out) &&
          !(prev_st == 1 && int'(sc.state_out) == 2)) r_bad_d++;
      prev_ck = sc.CK_SC_out;
      prev_d  = sc.D_SC_out;
      prev_st = int'(sc.state_out);
      if (sc.done_out) begin
        r_done       = k;
        r_done_d     = sc.D_SC_out;
        r_done_ck    = sc.CK_SC_out;
        r_done_state = int'(sc.state_out);
        r_err        = sc.err_out;
        r_cnt        = int'(sc.mismatch_cnt_out);
        if (!keep_start) sc.start_in = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_xfer(input string tag, input vec_t v);
    chk({tag, ".done_cycle"}, r_done, v.exp_done);
    chk({tag, ".ck_rises"}, r_rises, v.exp_rises);
    chk({tag, ".rstn_low_cycles"}, r_rst_low, 3);
    chk({tag, ".rstn_first"}, r_rst_first, 1);
    chk({tag, ".rstn_last"}, r_rst_last, 3);
    chk({tag, ".first_rise"}, r_first_rise, 6);
    chk({tag, ".rise_spacing_errs"}, r_bad_space, 0);
    chk({tag, ".d_change_errs"}, r_bad_d, 0);
    chk({tag, ".busy_low_cycles"}, r_busy_low, 0);
    chk({tag, ".err_after_start"}, r_err_k1, 0);
    chk({tag, ".pass1_bits"}, int'(r_pass1), int'(v.frame));
    if (v.ve) chk({tag, ".pass2_bits"}, int'(r_pass2), int'(v.frame));
    chk({tag, ".done_d"}, int'(r_done_d), 0);
    chk({tag, ".done_ck"}, int'(r_done_ck), 0);
    chk({tag, ".done_state"}, r_done_state, 3);
    chk({tag, ".err"}, int'(r_err), int'(v.exp_err));
    chk({tag, ".mismatch_cnt"}, r_cnt, v.exp_cnt);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".state"}, int'(sc.state_out), 0);
    chk({tag, ".busy"}, int'(sc.busy_out), 0);
    chk({tag, ".done"}, int'(sc.done_out), 0);
    chk({tag, ".d"}, int'(sc.D_SC_out), 0);
    chk({tag, ".ck"}, int'(sc.CK_SC_out), 0);
    chk({tag, ".rstn"}, int'(sc.RSTn_SC_out), 1);
  endtask

  initial begin
    vec_t v;
    int   d_rises, d_zero_bits, d_done;
    logic d_prev_ck;

    vecs[0] = '{16'hA5C3, 1'b0, 1'b0,  68, 16, 1'b0, 0};
    vecs[1] = '{16'h1234, 1'b1, 1'b0, 132, 32, 1'b0, 0};
    vecs[2] = '{16'h00FF, 1'b1, 1'b1, 132, 32, 1'b1, 8};
    vecs[3] = '{16'h8001, 1'b1, 1'b1, 132, 32, 1'b1, 2};
    vecs[4] = '{16'h0000, 1'b1, 1'b1, 132, 32, 1'b0, 0};
    vecs[5] = '{16'hFFFF, 1'b0, 1'b0,  68, 16, 1'b0, 0};

    rst_n = 1'b0;
    zero_q = 1'b0;
    sc.start_in = 1'b0; sc.verify_en_in = 1'b0; sc.frame_in = '0;
    scd.start_in = 1'b0; scd.verify_en_in = 1'b0; scd.frame_in = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    chk("reset.err", int'(sc.err_out), 0);
    chk("reset.mismatch_cnt", int'(sc.mismatch_cnt_out), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // The spec waveform for 16'hA5C3, bit by bit at each CK_SC rise.
    launch(vecs[0].frame, vecs[0].ve);
    sc.start_in = 1'b0;
    capture(1'b0, 1'b0, 400);
    chk("a5c3.rise_bits", int'(r_pass1), int'(16'b1010_0101_1100_0011));
    @(negedge clk);
    check_idle("a5c3.after");

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      zero_q = v.zq;
      launch(v.frame, v.ve);
      sc.start_in = 1'b0;
      capture(1'b0, 1'b0, 400);
      check_xfer($sformatf("vec%0d", i), v);
      @(negedge clk);
      check_idle($sformatf("vec%0d.after", i));
      chk($sformatf("vec%0d.err_sticky", i), int'(sc.err_out), int'(v.exp_err));
    end
    zero_q = 1'b0;

    // Reset asserted for one edge during bit 5 of SHIFT.
    launch(16'hA5C3, 1'b0);
    sc.start_in = 1'b0;
    repeat (24) @(negedge clk);
    chk("midrst.in_shift", int'(sc.state_out), 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("midrst");
    chk("midrst.err", int'(sc.err_out), 0);
    chk("midrst.mismatch_cnt", int'(sc.mismatch_cnt_out), 0);
    @(negedge clk);
    check_idle("midrst.stays_idle");
    launch(vecs[0].frame, 1'b0);
    sc.start_in = 1'b0;
    capture(1'b0, 1'b0, 400);
    check_xfer("midrst.resend", vecs[0]);
    @(negedge clk);

    // start re-pulsed and frame changed to all ones mid-transfer.
    v = '{16'h5A3C, 1'b0, 1'b0, 68, 16, 1'b0, 0};
    launch(v.frame, v.ve);
    sc.start_in = 1'b0;
    capture(1'b1, 1'b0, 400);
    check_xfer("disturb", v);
    @(negedge clk);
    check_idle("disturb.after");

    // start held high: back-to-back transfers with a single IDLE cycle.
    v = '{16'h0F0F, 1'b0, 1'b0, 68, 16, 1'b0, 0};
    launch(v.frame, v.ve);
    capture(1'b0, 1'b1, 400);
    check_xfer("hold.first", v);
    @(negedge clk);
    chk("hold.gap_state", int'(sc.state_out), 0);
    chk("hold.gap_busy", int'(sc.busy_out), 0);
    chk("hold.gap_rstn", int'(sc.RSTn_SC_out), 1);
    capture(1'b0, 1'b0, 400);
    check_xfer("hold.second", v);
    @(negedge clk);
    check_idle("hold.after");

    // Default parameters: 829-bit all-ones frame, DIV=1, RST_CYC=4.
    @(negedge clk);
    scd.frame_in = '1;
    scd.verify_en_in = 1'b0;
    scd.start_in = 1'b1;
    @(posedge clk);
    #1;
    scd.start_in = 1'b0;
    d_rises = 0; d_zero_bits = 0; d_done = -1; d_prev_ck = 1'b0;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (scd.CK_SC_out && !d_prev_ck) begin
        d_rises++;
        if (!scd.D_SC_out) d_zero_bits++;
      end
      d_prev_ck = scd.CK_SC_out;
      if (scd.done_out) begin
        d_done = k;
        break;
      end
    end
    chk("default.done_cycle", d_done, 4 + 1658 + 1);
    chk("default.ck_rises", d_rises, 829);
    chk("default.zero_bits", d_zero_bits, 0);
    chk("default.err", int'(scd.err_out), 0);
    @(negedge clk);
    chk("default.after_state", int'(scd.state_out), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sc_frame_serializer.md
# sc_frame_serializer

Parametrised slow-control frame serializer for daisy-chained MAROC front-end ASICs. It latches a full configuration frame of FRAME_W bits per chip times N_CHIP chips. It pulses the chip slow-control reset, then shifts the frame out LSB-first on D_SC_out with a divided CK_SC_out. An optional second pass reads the chain back on Q_SC_in and compares every bit against the frame that was sent. It sits between the configuration register bank and the ASIC slow-control pins, and supersedes the fixed 829-bit single-chip transmitter.

## Interface
- FRAME_W, 829: bits per chip frame; bit 0 = ON_OFF_otabg, bits 828:765 = Ctest_ch.
- N_CHIP, 1: chips in daisy chain. TOTAL = FRAME_W*N_CHIP; must be ≥1.
- DIV, 1: CK_SC half-period in clk_in cycles; must be ≥1.
- RST_CYC, 4: RSTn_SC_out low duration in cycles; must be ≥1.
- clk_in  in  1  system clock; all logic on rising edge.
- reset_in  in  1  synchronous, active-low reset.
- start_in  in  1  level; sampled only in IDLE.
- verify_en_in  in  1  sampled with start_in; 1 = add readback pass.
- frame_in  in  TOTAL  frame; chip 0 occupies bits FRAME_W-1:0 and is shifted first.
- Q_SC_in  in  1  serial output of the last chip in the chain.
- D_SC_out  out  1  serial data.
- RSTn_SC_out  out  1  chip slow-control reset, active-low.
- CK_SC_out  out  1  slow-control shift clock.
- busy_out  out  1  high in any state except IDLE.
- done_out  out  1  one-cycle pulse in DONE.
- err_out  out  1  sticky readback mismatch flag; cleared on accepted start.
- mismatch_cnt_out  out  16  readback mismatches, saturating at 16'hFFFF.
- state_out  out  3  0 IDLE, 1 RST, 2 SHIFT, 3 DONE, 4 READBACK.

## Operation
- Reset (reset_in=0 at an edge) forces the following values, even mid-transfer, with no partial-frame completion:
  - D_SC_out=0, CK_SC_out=0, RSTn_SC_out=1.
  - busy_out=0, done_out=0, err_out=0, mismatch_cnt_out=0, state IDLE.
- IDLE, start_in=1:
  - Latch frame_in into the shadow register and verify_en_in into the mode flag.
  - Clear err_out and mismatch_cnt_out; go to RST.
  - frame_in and verify_en_in changes after this edge are ignored.
- RST: RSTn_SC_out=0 for exactly RST_CYC cycles, CK_SC_out=0; then go to SHIFT with bit index 0.
- SHIFT: for each bit i = 0..TOTAL-1:
  - D_SC_out = shadow[i] for 2*DIV cycles.
  - CK_SC_out low for the first DIV cycles, high for the last DIV cycles.
  - After bit TOTAL-1's high phase: go to READBACK if the mode flag is set, else DONE.
- READBACK:
  - Identical bit timing and D_SC_out data as SHIFT; RSTn_SC_out stays 1.
  - In the last low-phase cycle of bit i (before CK_SC rises), sample Q_SC_in and compare with shadow[i].
  - On mismatch: err_out←1 and mismatch_cnt_out increments, saturating.
  - After bit TOTAL-1: go to DONE.
- DONE: done_out=1 for one cycle, CK_SC_out=0; then go to IDLE.
- start_in outside IDLE is ignored. If start is held high, a new transfer is accepted in the first IDLE cycle after DONE.
- Bit counter width is clog2(TOTAL); the phase counter counts 0..2*DIV-1. No wrap beyond TOTAL-1.

## Timing
- Start accepted at edge t0: state=RST and RSTn_SC_out=0 from t0+1 through t0+RST_CYC.
- First SHIFT cycle is t0+RST_CYC+1. CK_SC_out first rises DIV cycles later.
- One pass P = 2*DIV*TOTAL cycles.
- done_out is high in cycle t0+RST_CYC+P+1 without verify, or t0+RST_CYC+2P+1 with verify.
- IDLE resumes the following cycle; a held start produces the next RSTn_SC_out low one cycle after that.
- D_SC_out changes only in the cycle CK_SC_out falls (or at the SHIFT/READBACK entry). It is stable DIV cycles before and DIV cycles after every CK_SC rising edge.
- D_SC_out returns to 0 in DONE/IDLE.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Bench parameters: FRAME_W=8, N_CHIP=2, DIV=2, RST_CYC=3.
  - Stimulus: frame_in=16'hA5C3, verify_en_in=0, start pulse.
  - Required response: RSTn low exactly 3 cycles, then 16 CK_SC rising edges spaced 4 cycles apart.
  - D_SC at each rising edge = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - done_out pulses at cycle t0+68; err_out=0.
- Verify pass, chain model delays D_SC by 16 CK_SC edges: frame_in=16'h1234, verify_en_in=1 -> done at t0+132; err_out=0; mismatch_cnt_out=0.
- Verify pass, chain model forces Q_SC_in=0: frame_in=16'h00FF -> err_out=1; mismatch_cnt_out=8.
- reset_in=0 for one cycle while bit 5 of SHIFT is in progress -> next cycle state 0, all outputs at reset values. A subsequent start_in then sends a complete 16-bit frame.
- start_in re-pulsed during SHIFT, and frame_in changed to 16'hFFFF mid-frame -> both ignored; the original frame is transmitted unaltered.
- start_in held high continuously -> back-to-back transfers. RSTn goes low 2 cycles after each done_out pulse (one IDLE cycle between them).
- Default parameters, all-ones frame -> 829 CK_SC edges; done_out at t0+4+1658+1.
